// File: rtl/req_ack_stream_checker.sv
// Initiator end of the req/ack pull handshake: pulls tokens, checks them against an
// affine sequence and reports count, mismatch, timing, watchdog and protocol status.
module req_ack_stream_checker #(
    parameter int unsigned            DataWidth     = 32,
    parameter int unsigned            MaxCount      = 5000,
    parameter logic [DataWidth-1:0]   ExpInit       = '0,
    parameter logic [DataWidth-1:0]   ExpStep       = 1,
    parameter int unsigned            GapCycles     = 0,
    parameter int unsigned            TimeoutCycles = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    output logic                 req_o,
    input  logic                 ack_i,
    input  logic [DataWidth-1:0] din_i,
    output logic [31:0]          count_o,
    output logic [31:0]          err_count_o,
    output logic [31:0]          first_err_idx_o,
    output logic [DataWidth-1:0] first_err_data_o,
    output logic [31:0]          cycles_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic                 proto_err_o
);

    typedef enum logic [1:0] {StIdle, StReq, StGap, StDone} state_e;

    localparam logic [31:0] Sat = '1;

    state_e               state_q, state_d;
    logic [DataWidth-1:0] exp_q, exp_d;
    logic [31:0]          count_q, count_d;
    logic [31:0]          err_q, err_d;
    logic [31:0]          fidx_q, fidx_d;
    logic [DataWidth-1:0] fdata_q, fdata_d;
    logic [31:0]          cycles_q, cycles_d;
    logic                 started_q, started_d;
    logic [31:0]          gap_q, gap_d;
    logic [31:0]          wd_q, wd_d;
    logic                 timeout_q, timeout_d;
    logic                 proto_q, proto_d;
    logic                 accept;

    assign accept = (state_q == StReq) && ack_i;

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        count_d   = count_q;
        err_d     = err_q;
        fidx_d    = fidx_q;
        fdata_d   = fdata_q;
        cycles_d  = cycles_q;
        started_d = started_q;
        gap_d     = gap_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        proto_d   = proto_q;

        if (accept) begin
            if (count_q != Sat) count_d = count_q + 32'd1;
            if (din_i != exp_q) begin
                if (err_q != Sat) err_d = err_q + 32'd1;
                if (err_q == '0) begin
                    fidx_d  = count_q;
                    fdata_d = din_i;
                end
            end
            exp_d = exp_q + ExpStep;
        end

        // Watchdog only runs while a request is outstanding.
        if ((state_q == StReq) && !ack_i) begin
            if (wd_q != Sat) wd_d = wd_q + 32'd1;
        end else begin
            wd_d = '0;
        end
        if ((TimeoutCycles != 0) && (wd_d >= TimeoutCycles)) timeout_d = 1'b1;

        if (ack_i && (state_q != StReq)) proto_d = 1'b1;

        if (state_q == StReq) started_d = 1'b1;
        if ((state_q != StDone) && ((state_q == StReq) || started_q) && (cycles_q != Sat)) begin
            cycles_d = cycles_q + 32'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (en_i) state_d = StReq;
            end
            StReq: begin
                if (ack_i) begin
                    if ((MaxCount != 0) && (count_d == MaxCount)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StGap;
                        gap_d   = '0;
                    end
                end
            end
            StGap: begin
                // Holds req low for GapCycles + 1 cycles, then re-evaluates en.
                if (gap_q == GapCycles) begin
                    state_d = en_i ? StReq : StIdle;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            exp_q     <= ExpInit;
            count_q   <= '0;
            err_q     <= '0;
            fidx_q    <= '0;
            fdata_q   <= '0;
            cycles_q  <= '0;
            started_q <= 1'b0;
            gap_q     <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            proto_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            count_q   <= count_d;
            err_q     <= err_d;
            fidx_q    <= fidx_d;
            fdata_q   <= fdata_d;
            cycles_q  <= cycles_d;
            started_q <= started_d;
            gap_q     <= gap_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            proto_q   <= proto_d;
        end
    end

    assign req_o            = (state_q == StReq);
    assign done_o           = (state_q == StDone);
    assign count_o          = count_q;
    assign err_count_o      = err_q;
    assign first_err_idx_o  = fidx_q;
    assign first_err_data_o = fdata_q;
    assign cycles_o         = cycles_q;
    assign timeout_o        = timeout_q;
    assign proto_err_o      = proto_q;

endmodule

// File: tb/tb_req_ack_stream_checker.sv
// Bench for req_ack_stream_checker: cycle-level behavioural model with per-cycle compare,
// directed responder scenarios and literal spot checks.
module tb_req_ack_stream_checker;

    localparam int unsigned DW       = 8;
    localparam int unsigned MaxCount = 5;
    localparam int unsigned ExpInit  = 2;
    localparam int unsigned ExpStep  = 3;
    localparam int unsigned Gap      = 3;
    localparam int unsigned Tmo      = 16;

    logic          clk = 1'b0;
    logic          rst, en, ack;
    logic [DW-1:0] din;
    logic          req_o, done_o, timeout_o, proto_o;
    logic [31:0]   count_o, err_o, fidx_o, cycles_o;
    logic [DW-1:0] fdata_o;

    logic          rst_b, en_b, ack_b;
    logic [DW-1:0] din_b;
    logic          req_b, done_b, timeout_b, proto_b;
    logic [31:0]   count_b, err_b, fidx_b, cycles_b;
    logic [DW-1:0] fdata_b;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    req_ack_stream_checker #(
        .DataWidth(DW), .MaxCount(MaxCount), .ExpInit(8'(ExpInit)), .ExpStep(8'(ExpStep)),
        .GapCycles(Gap), .TimeoutCycles(Tmo)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .req_o(req_o), .ack_i(ack), .din_i(din),
        .count_o(count_o), .err_count_o(err_o), .first_err_idx_o(fidx_o),
        .first_err_data_o(fdata_o), .cycles_o(cycles_o), .done_o(done_o),
        .timeout_o(timeout_o), .proto_err_o(proto_o)
    );

    req_ack_stream_checker #(
        .DataWidth(DW), .MaxCount(1), .ExpInit(8'd0), .ExpStep(8'd1),
        .GapCycles(0), .TimeoutCycles(0)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst_b), .en_i(en_b), .req_o(req_b), .ack_i(ack_b), .din_i(din_b),
        .count_o(count_b), .err_count_o(err_b), .first_err_idx_o(fidx_b),
        .first_err_data_o(fdata_b), .cycles_o(cycles_b), .done_o(done_b),
        .timeout_o(timeout_b), .proto_err_o(proto_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: token index drives the expected value directly.
    int        m_count, m_err, m_fidx, m_gap, m_wd;
    logic [31:0] m_cycles;
    logic [DW-1:0] m_fdata;
    bit        m_req, m_done, m_started, m_tmo, m_perr;

    function automatic logic [DW-1:0] exp_of(input int idx);
        logic [31:0] v;
        v = 32'(ExpInit) + 32'(ExpStep) * 32'(idx);
        return v[DW-1:0];
    endfunction

    task automatic model_step();
        if (rst) begin
            m_count = 0; m_err = 0; m_fidx = 0; m_gap = 0; m_wd = 0; m_cycles = 0;
            m_fdata = '0; m_req = 0; m_done = 0; m_started = 0; m_tmo = 0; m_perr = 0;
            return;
        end
        if (!m_done && (m_req || m_started)) m_cycles++;
        if (m_req) m_started = 1;
        if (ack && !m_req) m_perr = 1;
        if (m_req) begin
            if (ack) begin
                if (din != exp_of(m_count)) begin
                    if (m_err == 0) begin
                        m_fidx  = m_count;
                        m_fdata = din;
                    end
                    m_err++;
                end
                m_count++;
                m_req = 0;
                m_wd  = 0;
                if (m_count == int'(MaxCount)) m_done = 1;
                else m_gap = Gap + 1;
            end else begin
                m_wd++;
                if (m_wd >= int'(Tmo)) m_tmo = 1;
            end
        end else if (!m_done) begin
            if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0 && en) m_req = 1;
            end else if (en) begin
                m_req = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("req", 32'(req_o), 32'(m_req));
            chk("count", count_o, 32'(m_count));
            chk("err_count", err_o, 32'(m_err));
            chk("first_err_idx", fidx_o, 32'(m_fidx));
            chk("first_err_data", 32'(fdata_o), 32'(m_fdata));
            chk("cycles", cycles_o, m_cycles);
            chk("done", 32'(done_o), 32'(m_done));
            chk("timeout", 32'(timeout_o), 32'(m_tmo));
            chk("proto_err", 32'(proto_o), 32'(m_perr));
        end
    end

    task automatic wait_req();
        int n = 0;
        while (req_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (req_o !== 1'b1) begin
            n_total++;
            $display("FAIL req_wait: req stayed %b, required 1", req_o);
        end
    endtask

    task automatic respond(input int lat, input logic [DW-1:0] val);
        wait_req();
        repeat (lat) @(negedge clk);
        ack = 1'b1;
        din = val;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic pulse_ack(input logic [DW-1:0] val);
        @(negedge clk);
        ack = 1'b1;
        din = val;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; ack = 1'b0; din = '0;
        rst_b = 1'b1; en_b = 1'b0; ack_b = 1'b0; din_b = '0;
        @(posedge clk);
        #1 cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_count", count_o, 32'd0);
        chk("reset_req", 32'(req_o), 32'd0);

        // Clean sequence 2,5,8,11,14.
        rst = 1'b0;
        en  = 1'b1;
        respond(1, 8'd2); respond(1, 8'd5); respond(1, 8'd8);
        respond(1, 8'd11); respond(1, 8'd14);
        repeat (3) @(negedge clk);
        chk("seq_count", count_o, 32'd5);
        chk("seq_err", err_o, 32'd0);
        chk("seq_done", 32'(done_o), 32'd1);
        chk("seq_req", 32'(req_o), 32'd0);
        chk("seq_proto", 32'(proto_o), 32'd0);
        chk("seq_cycles", cycles_o, 32'd26);
        pulse_ack(8'd17);
        chk("done_ack_proto", 32'(proto_o), 32'd1);
        chk("done_ack_count", count_o, 32'd5);

        // Mismatches at index 2 and 4.
        do_reset();
        respond(1, 8'd2); respond(1, 8'd5); respond(1, 8'd9);
        chk("mm1_err", err_o, 32'd1);
        chk("mm1_idx", fidx_o, 32'd2);
        chk("mm1_data", 32'(fdata_o), 32'd9);
        respond(1, 8'd11); respond(1, 8'd20);
        chk("mm2_err", err_o, 32'd2);
        chk("mm2_idx", fidx_o, 32'd2);
        chk("mm2_data", 32'(fdata_o), 32'd9);

        // Gap spacing with immediate acks, then a stray ack inside the gap.
        do_reset();
        respond(0, 8'd2);
        n = 0;
        while (!req_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("gap_low_cycles", 32'(n), 32'd4);
        respond(0, 8'd5);
        pulse_ack(8'd8);
        chk("gap_ack_proto", 32'(proto_o), 32'd1);
        chk("gap_ack_count", count_o, 32'd2);
        respond(1, 8'd8);
        chk("gap_ack_noadv", err_o, 32'd0);

        // Watchdog with a silent responder, then a late ack.
        do_reset();
        wait_req();
        n = 0;
        while (!timeout_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_latency", 32'(n), 32'd16);
        chk("tmo_req_held", 32'(req_o), 32'd1);
        pulse_ack(8'd2);
        chk("tmo_late_count", count_o, 32'd1);
        chk("tmo_late_err", err_o, 32'd0);

        // Two-cycle ack in REQ.
        do_reset();
        wait_req();
        ack = 1'b1;
        din = 8'd2;
        repeat (2) @(negedge clk);
        ack = 1'b0;
        chk("ack2_count", count_o, 32'd1);
        chk("ack2_proto", 32'(proto_o), 32'd1);

        // Reset mid-REQ with a pending ack, then restart and park in IDLE.
        do_reset();
        respond(1, 8'd2); respond(1, 8'd5); respond(1, 8'd8);
        wait_req();
        rst = 1'b1;
        ack = 1'b1;
        din = 8'd11;
        @(negedge clk);
        rst = 1'b0;
        ack = 1'b0;
        chk("rst_count", count_o, 32'd0);
        chk("rst_cycles", cycles_o, 32'd0);
        chk("rst_req", 32'(req_o), 32'd0);
        chk("rst_proto", 32'(proto_o), 32'd0);
        respond(1, 8'd2);
        chk("restart_count", count_o, 32'd1);
        chk("restart_err", err_o, 32'd0);
        en = 1'b0;
        repeat (12) @(negedge clk);
        chk("park_req", 32'(req_o), 32'd0);
        en = 1'b1;
        respond(1, 8'd5);
        chk("unpark_count", count_o, 32'd2);

        // Second instance: max_count=1, ack four cycles after req rises.
        @(negedge clk);
        rst_b = 1'b0;
        en_b  = 1'b1;
        n = 0;
        while (!req_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        ack_b = 1'b1;
        din_b = 8'd0;
        @(negedge clk);
        ack_b = 1'b0;
        chk("b_cycles", cycles_b, 32'd5);
        chk("b_count", count_b, 32'd1);
        chk("b_done", 32'(done_b), 32'd1);
        chk("b_req", 32'(req_b), 32'd0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
